// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and grant-id width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TAG  = 2'd1,
        ARB_PASS = 2'd2
    } arb_state_e;

    function automatic int arb_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin first-set search: lowest-distance set bit at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = IDW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter feeding one UART TX byte stream from N_REQ requesters.
// Define UART_ARB_TAG_EN to prefix every message with a TAG_BASE+grant_id tag byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter int         TIMEOUT  = 1024,
`ifdef UART_ARB_TAG_EN
    parameter logic [7:0] TAG_BASE = 8'h30,
`endif
    localparam int        IDW      = arb_idw(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic [IDW-1:0]     grant_id,
    output logic               busy
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] ptr_next;

    rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Pointer after releasing the current owner: the next requester gets top priority.
    assign ptr_next = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                    state_d = ARB_TAG;
`else
                    state_d = ARB_PASS;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ARB_TAG: begin
                tx_valid = 1'b1;
                tx_data  = TAG_BASE + 8'(grant_q);
                if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = ARB_PASS;
                end
            end
`endif
            ARB_PASS: begin
                tx_valid           = req_valid[grant_q];
                tx_data            = req_data[8*grant_q +: 8];
                req_ready[grant_q] = tx_ready;
                if (req_valid[grant_q]) begin
                    // Stalled bytes hold the idle count; only a real transfer clears it.
                    if (tx_ready) begin
                        cnt_d = '0;
                        if (req_last[grant_q]) begin
                            ptr_d   = ptr_next;
                            state_d = ARB_IDLE;
                        end
                    end
                end else if (cnt_q == CNT_MAX) begin
                    ptr_d   = ptr_next;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter plus directed arbitration, timeout and reset cases.
module tb_uart_tx_arbiter;

    localparam int         N_REQ   = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [7:0] TAGB    = 8'h30;
    localparam int         MSGS    = 25;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ*8-1:0] req_data = '0;
    logic [N_REQ-1:0]   req_last = '0;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready = 1'b0;
    logic [1:0]         grant_id;
    logic               busy;

    uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int id; logic [7:0] data; bit tag; } exp_t;
    typedef struct { int id; logic [7:0] data; bit tag; int cyc; logic rdy; } ent_t;

    exp_t sb[$];
    ent_t txlog[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    bit   rnd_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: message-level ownership, idle-run counting and rotating priority.
    int m_owner = -1;
    int m_ptr = 0;
    int m_idle = 0;
    bit m_tag = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_idle = 0; m_tag = 1'b0;
            sb.delete();
        end else if (m_owner < 0) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N_REQ]) begin
                    m_owner = (m_ptr + k) % N_REQ;
                    m_tag   = TAG_EN;
                    m_idle  = 0;
                end
            end
        end else if (m_tag) begin
            if (tx_ready) begin
                sb.push_back('{m_owner, 8'(TAGB + 8'(m_owner)), 1'b1});
                m_tag = 1'b0;
            end
        end else if (req_valid[m_owner]) begin
            if (tx_ready) begin
                sb.push_back('{m_owner, req_data[8*m_owner +: 8], 1'b0});
                m_idle = 0;
                if (req_last[m_owner]) begin
                    m_ptr = (m_owner + 1) % N_REQ;
                    m_owner = -1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_ptr = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end
        end
    end

    // Monitor: every accepted byte must match the oldest predicted byte.
    initial forever begin
        exp_t e;
        @(negedge clk); #1;
        if (rst_n) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_tx: got byte 0x%0h from id %0d, expected no transfer", tx_data, grant_id);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e.data));
                    chk("tx_grant", 32'(grant_id), 32'(e.id));
                    chk("req_ready_fwd", 32'(req_ready[grant_id]), 32'(!e.tag));
                    txlog.push_back('{int'(grant_id), tx_data, e.tag, cyc, req_ready[grant_id]});
                end
            end
        end
    end

    task automatic wait_hs(input int i);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready[i]) break;
            n++;
            if (n > 4000) begin
                n_checks++; n_errors++;
                $display("FAIL hs_timeout_req%0d: no req_ready after %0d cycles, expected a handshake", i, n);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_msg(input int i, input int n, input bit use_last, input int max_gap);
        for (int b = 0; b < n; b++) begin
            req_data[8*i +: 8] = 8'($urandom);
            req_valid[i] = 1'b1;
            req_last[i]  = use_last && (b == n - 1);
            wait_hs(i);
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drive(input int i);
        repeat (MSGS) begin
            bit drop;
            repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
            drop = ($urandom_range(0, 9) == 0);
            send_msg(i, $urandom_range(1, 4), !drop, 3);
            if (drop) repeat (TIMEOUT + 4) begin @(posedge clk); #1; end
        end
        done_cnt++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        txlog.delete();
    endtask

    initial begin
        int ids[$];
        int cs[$];
        int n;
        bit ok;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        // Reset while requester 2 owns the stream and is stalled mid-message.
        do_reset();
        req_data[23:16] = 8'h77; req_valid[2] = 1'b1; req_last[2] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midmsg_busy", 32'(busy), 1);
        chk("midmsg_grant", 32'(grant_id), 2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx_valid", 32'(tx_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_req_ready", 32'(req_ready), 0);
        req_valid[2] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_grant", 32'(grant_id), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // Fairness: everyone valid with 1-byte messages.
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        req_valid = '1; req_last = '1;
        repeat (16) begin @(posedge clk); #1; end
        req_valid = '0;
        repeat (30) begin @(posedge clk); #1; end
        ids.delete(); cs.delete();
        foreach (txlog[k]) if (!txlog[k].tag) begin ids.push_back(txlog[k].id); cs.push_back(txlog[k].cyc); end
        chk("fair_count", 32'(ids.size() >= 5), 1);
        for (int k = 0; k < 5 && k < ids.size(); k++) chk($sformatf("fair_order%0d", k), 32'(ids[k]), 32'(k % N_REQ));
        for (int k = 1; k < 5 && k < cs.size(); k++) chk($sformatf("fair_gap%0d", k), 32'(cs[k] - cs[k-1]), TAG_EN ? 3 : 2);

        // Lock: requester 1's three-byte message is not interrupted by requester 2.
        do_reset();
        tx_ready = 1'b1;
        req_data[23:16] = 8'h22; req_valid[2] = 1'b1; req_last[2] = 1'b1;
        send_msg(1, 3, 1'b1, 0);
        wait_hs(2);
        req_valid[2] = 1'b0; req_last[2] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ids.delete();
        foreach (txlog[k]) if (!txlog[k].tag) ids.push_back(txlog[k].id);
        chk("lock_count", 32'(ids.size()), 4);
        for (int k = 0; k < 4 && k < ids.size(); k++) chk($sformatf("lock_order%0d", k), 32'(ids[k]), (k < 3) ? 1 : 2);

        // Timeout: one byte without last, then silence.
        do_reset();
        tx_ready = 1'b1;
        send_msg(0, 1, 1'b0, 0);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("timeout_cycles", 32'(n), TIMEOUT);
        @(posedge clk); #1;
        txlog.delete();
        req_data[7:0] = 8'hA0; req_data[15:8] = 8'hA1;
        req_valid[1:0] = 2'b11; req_last[1:0] = 2'b11;
        wait_hs(1);
        req_valid[1] = 1'b0;
        wait_hs(0);
        req_valid[0] = 1'b0;
        ids.delete();
        foreach (txlog[k]) if (!txlog[k].tag) ids.push_back(txlog[k].id);
        chk("timeout_ptr_next", 32'(ids.size() > 0 ? ids[0] : -1), 1);

        // Back-pressure: a stalled byte never releases and stays stable.
        do_reset();
        req_data[7:0] = 8'h5A; req_valid[0] = 1'b1; req_last[0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx_data !== (TAG_EN ? TAGB : 8'h5A) || req_ready !== '0 || busy !== 1'b1 || tx_valid !== 1'b1) ok = 1'b0;
        end
        chk("backpressure_hold", 32'(ok), 1);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_hs(0);
        req_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

`ifdef UART_ARB_TAG_EN
        do_reset();
        tx_ready = 1'b1;
        req_data[23:16] = 8'h41; req_valid[2] = 1'b1; req_last[2] = 1'b1;
        wait_hs(2);
        req_valid[2] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("tag_count", 32'(txlog.size()), 2);
        if (txlog.size() >= 2) begin
            chk("tag_byte", 32'(txlog[0].data), 32'h32);
            chk("tag_ready_low", 32'(txlog[0].rdy), 0);
            chk("tag_payload", 32'(txlog[1].data), 32'h41);
        end
`endif

        // Random traffic against the reference model.
        do_reset();
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    tx_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk); #1;
                end
            end
            drive(0);
            drive(1);
            drive(2);
            drive(3);
        join_none
        for (int c = 0; c < 60000 && done_cnt < N_REQ; c++) @(posedge clk);
        chk("drivers_done", 32'(done_cnt), N_REQ);
        #1;
        rnd_on = 1'b0;
        tx_ready = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        chk("scoreboard_empty", 32'(sb.size()), 0);
        chk("final_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
